// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state enum lives here so every slice of the loader agrees on it.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      DATA,
      WRITE,
      CHECK
   } state_t;

   localparam int MAX_WORDS      = 128;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler for the loader.
// word is the completed word in the cycle its final byte sits on din.
module word_assembler
   import imem_loader_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [7:0]   din,
   output logic [N-1:0] word,
   output logic         word_full
);

   logic [N-9:0] sr;
   logic [1:0]   bcnt;

   // shift each byte in from the top; the last byte comes straight from din
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr   <= '0;
         bcnt <= '0;
      end else if (clear) begin
         sr   <= '0;
         bcnt <= '0;
      end else if (load) begin
         sr   <= {din, sr[N-9:8]};
         bcnt <= bcnt + 2'd1;
      end
   end

   assign word      = {din, sr};
   assign word_full = (bcnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, checksummed byte image into instruction RAM
// while holding the processor in reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int N  = 32,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [N-1:0]  wdata,
   output logic          busy,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   state_t       state;
   logic [AW:0]  widx;
   logic [AW:0]  nidx;
   logic [AW:0]  total;
   logic [7:0]   chk;
   logic         xfer;
   logic         kill;
   logic         asm_clear;
   logic         asm_load;
   logic         word_full;
   logic [N-1:0] word;

   assign in_ready = (state == COUNT) || (state == DATA) || (state == CHECK);
   assign kill     = abort && (state != IDLE);
   assign xfer     = in_valid && in_ready && !abort;
   assign busy     = (state != IDLE);
   assign cpu_hold = busy;
   assign waddr    = widx[AW-1:0];
   assign nidx     = widx + (AW+1)'(1);

   assign asm_clear = ((state == IDLE) && start) || kill;
   assign asm_load  = xfer && (state == DATA);

   word_assembler #(.N(N)) u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .load      (asm_load),
      .din       (in_data),
      .word      (word),
      .word_full (word_full)
   );

   // load sequencer: count byte, data words, then the checksum byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         widx  <= '0;
         total <= '0;
         chk   <= '0;
         wdata <= '0;
         we    <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         we   <= 1'b0;
         done <= 1'b0;
         if (kill) begin
            state <= IDLE;
            err   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= COUNT;
                     err   <= 1'b0;
                     widx  <= '0;
                     chk   <= '0;
                  end
               end
               COUNT: begin
                  if (xfer) begin
                     if (in_data > 8'd128) begin
                        err   <= 1'b1;
                        state <= IDLE;
                     end else begin
                        if (in_data == 8'd0)
                           total <= (AW+1)'(MAX_WORDS);
                        else
                           total <= (AW+1)'(in_data);
                        state <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (xfer) begin
                     chk <= chk ^ in_data;
                     if (word_full) begin
                        wdata <= word;
                        we    <= 1'b1;
                        state <= WRITE;
                     end
                  end
               end
               WRITE: begin
                  widx  <= nidx;
                  state <= (nidx == total) ? CHECK : DATA;
               end
               CHECK: begin
                  if (xfer) begin
                     state <= IDLE;
                     if (in_data == chk)
                        done <= 1'b1;
                     else
                        err  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader.
// Expected writes, done and err come from the image bytes themselves.
module tb_imem_loader;

   typedef struct {
      logic [6:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        we;
   logic [6:0]  waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        cpu_hold;
   logic        done;
   logic        err;

   int   checks;
   int   fails;
   int   done_cnt;
   int   viol;
   wr_t  wr_q[$];
   logic [7:0] byte_q[$];

   imem_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record every write and done cycle; a write with in_ready high is a violation
   always @(negedge clk) begin
      wr_t w;
      if (we) begin
         w.a = waddr;
         w.d = wdata;
         wr_q.push_back(w);
         if (in_ready) viol++;
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      while (gap > 0 && $urandom_range(99) < gap) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("ready_wait", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // chk_byte < 0 sends the correct checksum
   task automatic run_load(input bit do_start, input logic [7:0] cnt,
                           input int chk_byte, input int gap,
                           input string tag);
      int n;
      int bw;
      int bd;
      logic [7:0]  sum;
      logic [7:0]  cb;
      logic [31:0] ew;
      bit good;
      n  = (cnt == 8'd0) ? 128 : int'(cnt);
      bw = wr_q.size();
      bd = done_cnt;
      if (do_start) pulse_start();
      send_byte(cnt, gap);
      if (cnt > 8'd128) begin
         repeat (2) @(negedge clk);
         check({tag, "_err"}, err, 1);
         check({tag, "_nwr"}, wr_q.size() - bw, 0);
         check({tag, "_busy"}, busy, 0);
         return;
      end
      sum = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
         sum ^= byte_q[i];
         send_byte(byte_q[i], gap);
      end
      cb = (chk_byte < 0) ? sum : chk_byte[7:0];
      good = (cb == sum);
      send_byte(cb, gap);
      repeat (2) @(negedge clk);
      check({tag, "_nwr"}, wr_q.size() - bw, n);
      for (int i = 0; i < n && bw + i < wr_q.size(); i++) begin
         ew = 32'(byte_q[4*i])
            + 32'(byte_q[4*i+1]) * 32'd256
            + 32'(byte_q[4*i+2]) * 32'd65536
            + 32'(byte_q[4*i+3]) * 32'd16777216;
         check({tag, "_addr"}, wr_q[bw+i].a, i);
         check({tag, "_data"}, wr_q[bw+i].d, ew);
      end
      check({tag, "_done"}, done_cnt - bd, good ? 1 : 0);
      check({tag, "_err"}, err, good ? 0 : 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_hold"}, cpu_hold, 0);
   endtask

   initial begin
      int bw;
      int bd;
      logic [7:0] nb;
      checks   = 0;
      fails    = 0;
      done_cnt = 0;
      viol     = 0;
      reset    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_we", we, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_waddr", waddr, 0);
      check("rst_wdata", wdata, 0);
      reset = 1'b0;
      @(negedge clk);

      // single word
      byte_q.delete();
      byte_q = '{8'h01, 8'h00, 8'h00, 8'hF8};
      bw = wr_q.size();
      run_load(1, 8'h01, -1, 0, "one");
      check("one_lit", wr_q[bw].d, 32'hF8000001);

      // full 128-word image, checksum of an even repeat count is 0
      byte_q.delete();
      for (int i = 0; i < 128; i++) begin
         byte_q.push_back(8'h8B);
         byte_q.push_back(8'h1F);
         byte_q.push_back(8'h03);
         byte_q.push_back(8'hFF);
      end
      run_load(1, 8'h00, -1, 0, "full");

      // bad count, then start clears err
      run_load(1, 8'h81, -1, 0, "badcnt");
      pulse_start();
      check("start_clr_err", err, 0);
      check("start_busy", busy, 1);

      // bad checksum, continuing the load just started
      byte_q.delete();
      byte_q = '{8'h01, 8'h00, 8'h00, 8'hF8};
      run_load(0, 8'h01, 8'h00, 0, "badchk");

      // abort after two data bytes, with a third byte offered alongside
      bw = wr_q.size();
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h33;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_err", err, 1);
      repeat (2) @(negedge clk);
      check("abort_nwr", wr_q.size() - bw, 0);

      // abort coinciding with the byte that would complete a word
      bw = wr_q.size();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'hA1, 0);
      send_byte(8'hA2, 0);
      send_byte(8'hA3, 0);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hA4;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort4_nwr", wr_q.size() - bw, 0);
      check("abort4_err", err, 1);

      // backpressure: same 3-word image with and without gaps
      byte_q.delete();
      for (int i = 0; i < 12; i++) byte_q.push_back(8'($urandom));
      run_load(1, 8'h03, -1, 0, "bp_nogap");
      run_load(1, 8'h03, -1, 60, "bp_gap");
      check("bp_ready_in_write", viol, 0);

      // random loads
      for (int k = 0; k < 5; k++) begin
         nb = 8'($urandom_range(1, 6));
         byte_q.delete();
         for (int i = 0; i < 4 * int'(nb); i++)
            byte_q.push_back(8'($urandom));
         run_load(1, nb, ($urandom_range(3) == 0) ? int'($urandom_range(255)) : -1,
                  int'($urandom_range(50)), "rnd");
      end

      // reset mid-load
      bd = done_cnt;
      pulse_start();
      send_byte(8'h03, 0);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
      #2 reset = 1'b1;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_ready", in_ready, 0);
      check("mrst_we", we, 0);
      check("mrst_err", err, 0);
      check("mrst_waddr", waddr, 0);
      check("mrst_wdata", wdata, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("mrst_nodone", done_cnt - bd, 0);
      check("mrst_busy2", busy, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter N, default 32, instruction word width in bits.
REQ-002 Parameter AW, default 7, word-address width; capacity is 2**AW = 128 words.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 abort  input  1  single-cycle request to cancel a load in progress.
REQ-007 in_valid  input  1  byte available on in_data.
REQ-008 in_data  input  8  stream byte.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 we  output  1  instruction-RAM write strobe, one cycle per word.
REQ-011 waddr  output  AW  word address of the write.
REQ-012 wdata  output  N  instruction word being written.
REQ-013 busy  output  1  load in progress.
REQ-014 cpu_hold  output  1  holds the processor in reset; equals busy.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 err  output  1  sticky error flag; cleared by the next accepted start.

Function
REQ-017 A byte SHALL transfer on any rising edge where in_valid and in_ready are both 1; in_valid may drop between bytes.
REQ-018 States SHALL be IDLE, COUNT, DATA, WRITE, CHECK.
- IDLE: in_ready=0.
- COUNT, DATA, CHECK: in_ready=1.
- WRITE: in_ready=0.
REQ-019 From IDLE, start SHALL move the FSM to COUNT, clear err, reset the word index and checksum, and set busy.
REQ-020 start received in any state other than IDLE SHALL be ignored.
REQ-021 Byte accepted in COUNT:
- C = 0 means 128 words.
- C = 1..128 means C words; next state DATA.
- C > 128 sets err and returns to IDLE with no writes.
REQ-022 DATA SHALL assemble bytes little-endian: the first byte goes to wdata[7:0] and the fourth to wdata[31:24].
REQ-023 Acceptance of the fourth byte of a word SHALL move the FSM to WRITE.
REQ-024 In WRITE, the loader SHALL:
- drive we=1 for exactly one cycle, with waddr equal to the word index (starting at 0) and wdata equal to the assembled word;
- increment the word index;
- go to CHECK after the last word, otherwise return to DATA.
REQ-025 The checksum SHALL be the XOR of every data byte; the count byte is excluded.
REQ-026 Byte accepted in CHECK, next cycle:
- state returns to IDLE and busy=0;
- done=1 for one cycle if the byte equals the checksum;
- otherwise err=1 and done stays 0.
REQ-027 abort in any non-IDLE state SHALL force IDLE on the next edge, set err, suppress we, and leave no partial word written.
REQ-028 If abort and a byte transfer occur in the same cycle, abort SHALL win and the byte SHALL be dropped.
REQ-029 The word index SHALL be AW+1 bits wide, so that 128 words are counted without wrapping; waddr is its low AW bits.
REQ-030 we, done and err SHALL be registered outputs.
REQ-031 wdata SHALL hold its value outside of WRITE.

Reset
REQ-032 Asserting reset SHALL immediately:
- set the state to IDLE;
- drive busy, cpu_hold, in_ready, we, done and err to 0;
- set waddr, wdata, the word index and the checksum to 0.
REQ-033 Reset asserted mid-load SHALL abandon the load without a done pulse; err is not set.

Structure
REQ-034 Package imem_loader_pkg SHALL hold:
- the state enum;
- MAX_WORDS=128;
- BYTES_PER_WORD=4.
REQ-035 A sub-module word_assembler SHALL hold the 4-byte shift register and the 2-bit byte counter, with load/clear inputs and a word_full output.

Verification
REQ-036 Single word: start; send 01,01,00,00,F8,F9 -> one we with waddr=0 and wdata=32'hF8000001; done pulse; err=0.
REQ-037 Full image: count 00, then 512 bytes of 8B1F03FF repeated, with the correct checksum -> 128 writes at waddr 0..127, no wrap to 0; done=1.
REQ-038 Bad count: count 81 -> err=1, no we, return to IDLE; the next start clears err.
REQ-039 Bad checksum: 01,01,00,00,F8,00 -> one write, then err=1 and no done pulse.
REQ-040 Abort mid-word after 2 data bytes -> no we, err=1, busy=0 on the next cycle.
REQ-041 Backpressure: in_valid toggling randomly over a 3-word load -> the same wdata sequence as the gap-free run; in_ready=0 in every WRITE cycle.
